// File: rtl/q2_panel.sv
// q2_panel: front-panel controller feeding the q2 core.
// Debounces four push-buttons and synchronizes the data switches.
// A small FSM turns accepted presses into fixed-width strobes.
// Ports: clk, rst (async, active-low);
//   btn_incp/btn_dep/btn_start/btn_stop, sw_raw[11:0], run in;
//   incp_sw/dep_sw/start_sw/stop_sw, sw[11:0], busy out.
// Option: define Q2_PANEL_AUTOINC_EN to follow each deposit
//   with an automatic incp_sw strobe (DEP->DGAP->INC->GAP).
module q2_panel #(
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned PULSE    = 4,
    parameter int unsigned GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_incp,
    input  logic        btn_dep,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic [11:0] sw_raw,
    input  logic        run,
    output logic        incp_sw,
    output logic        dep_sw,
    output logic        start_sw,
    output logic        stop_sw,
    output logic [11:0] sw,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DEP   = 3'd1;
    localparam logic [2:0] S_DGAP  = 3'd2;
    localparam logic [2:0] S_INC   = 3'd3;
    localparam logic [2:0] S_START = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

`ifdef Q2_PANEL_AUTOINC_EN
    localparam logic [2:0] S_DEP_NXT = S_DGAP;
`else
    localparam logic [2:0] S_DEP_NXT = S_GAP;
`endif

    localparam int B_INCP  = 0;
    localparam int B_DEP   = 1;
    localparam int B_START = 2;
    localparam int B_STOP  = 3;

    localparam logic [15:0] DB_MAX = 16'(DEBOUNCE - 1);
    localparam logic [15:0] P_LD   = 16'(PULSE - 1);
    localparam logic [15:0] G_LD   = 16'(GAP - 1);

    logic [3:0]  btn_raw;
    logic [3:0]  b_s1;
    logic [3:0]  b_s2;
    logic [3:0]  b_db;
    logic [3:0]  b_db_q;
    logic [15:0] b_cnt [4];
    logic [3:0]  press;

    logic [11:0] sw_s1;
    logic [11:0] sw_s2;

    logic [2:0]  state;
    logic [2:0]  nxt;
    logic [15:0] tmr;
    logic        ld;
    logic [15:0] ld_val;

    assign btn_raw = {btn_stop, btn_start, btn_dep, btn_incp};

    // Counter reaching DB_MAX on a mismatching edge means the new
    // level has been seen DEBOUNCE times in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_s1   <= '0;
            b_s2   <= '0;
            b_db   <= '0;
            b_db_q <= '0;
            for (int i = 0; i < 4; i++) begin
                b_cnt[i] <= '0;
            end
        end else begin
            b_s1   <= btn_raw;
            b_s2   <= b_s1;
            b_db_q <= b_db;
            for (int i = 0; i < 4; i++) begin
                if (b_s2[i] != b_db[i]) begin
                    if (b_cnt[i] == DB_MAX) begin
                        b_db[i]  <= ~b_db[i];
                        b_cnt[i] <= '0;
                    end else begin
                        b_cnt[i] <= b_cnt[i] + 16'd1;
                    end
                end else begin
                    b_cnt[i] <= '0;
                end
            end
        end
    end

    assign press = b_db & ~b_db_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            sw    <= '0;
        end else begin
            sw_s1 <= sw_raw;
            sw_s2 <= sw_s1;
            if (state == S_IDLE) begin
                sw <= sw_s2;
            end
        end
    end

    // Events outside IDLE fall through untouched: nothing is queued.
    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = P_LD;
        unique case (state)
            S_IDLE: begin
                priority case (1'b1)
                    press[B_STOP]: begin
                        nxt = S_STOP;
                        ld  = 1'b1;
                    end
                    press[B_START]: begin
                        nxt = S_START;
                        ld  = 1'b1;
                    end
                    press[B_DEP] && !run: begin
                        nxt = S_DEP;
                        ld  = 1'b1;
                    end
                    press[B_INCP] && !run: begin
                        nxt = S_INC;
                        ld  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_DEP: begin
                if (tmr == '0) begin
                    nxt    = S_DEP_NXT;
                    ld     = 1'b1;
                    ld_val = G_LD;
                end
            end
            S_DGAP: begin
                if (tmr == '0) begin
                    nxt    = S_INC;
                    ld     = 1'b1;
                    ld_val = P_LD;
                end
            end
            S_INC, S_START, S_STOP: begin
                if (tmr == '0) begin
                    nxt    = S_GAP;
                    ld     = 1'b1;
                    ld_val = G_LD;
                end
            end
            S_GAP: begin
                if (tmr == '0) begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= nxt;
            if (ld) begin
                tmr <= ld_val;
            end else if (tmr != '0) begin
                tmr <= tmr - 16'd1;
            end
        end
    end

    assign incp_sw  = (state == S_INC);
    assign dep_sw   = (state == S_DEP);
    assign start_sw = (state == S_START);
    assign stop_sw  = (state == S_STOP);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_q2_panel.sv
// tb_q2_panel: scoreboard bench for q2_panel.
// DEBOUNCE=4, PULSE=2, GAP=1.
module tb_q2_panel;

    localparam int K_INC   = 0;
    localparam int K_DEP   = 1;
    localparam int K_START = 2;
    localparam int K_STOP  = 3;

    typedef struct {
        int kind;
        int rise;
        int width;
        int swv;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        btn_incp;
    logic        btn_dep;
    logic        btn_start;
    logic        btn_stop;
    logic [11:0] sw_raw;
    logic        run;
    logic        incp_sw;
    logic        dep_sw;
    logic        start_sw;
    logic        stop_sw;
    logic [11:0] sw;
    logic        busy;

    int   tests;
    int   fails;
    int   cyc;
    exp_t exp_q[$];
    int   idle_q[$];
    int   busy_rises;
    int   pulses;

    q2_panel #(
        .DEBOUNCE(4),
        .PULSE(2),
        .GAP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_incp(btn_incp),
        .btn_dep(btn_dep),
        .btn_start(btn_start),
        .btn_stop(btn_stop),
        .sw_raw(sw_raw),
        .run(run),
        .incp_sw(incp_sw),
        .dep_sw(dep_sw),
        .start_sw(start_sw),
        .stop_sw(stop_sw),
        .sw(sw),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input int kind, input int rise,
                        input int width, input int swv);
        exp_t e;
        e.kind  = kind;
        e.rise  = rise;
        e.width = width;
        e.swv   = swv;
        exp_q.push_back(e);
    endtask

    // Monitor: measures each strobe pulse and busy span,
    // then checks them against the scoreboard queues.
    logic [3:0]  m_vec;
    logic [3:0]  m_cur;
    logic        m_in;
    logic        m_busy_q;
    int          m_rise;
    int          m_w;
    int          m_kind;
    logic [11:0] m_sw;
    logic        m_sw_ok;

    initial begin
        m_in       = 1'b0;
        m_busy_q   = 1'b0;
        m_cur      = '0;
        busy_rises = 0;
        pulses     = 0;
    end

    always @(negedge clk) begin
        m_vec = {stop_sw, start_sw, dep_sw, incp_sw};
        if (!m_in && m_vec != 4'b0) begin
            m_in    = 1'b1;
            m_cur   = m_vec;
            m_rise  = cyc;
            m_w     = 1;
            m_sw    = sw;
            m_sw_ok = 1'b1;
            m_kind  = m_vec[3] ? K_STOP :
                      m_vec[2] ? K_START :
                      m_vec[1] ? K_DEP : K_INC;
            chk("onehot", $countones(m_vec), 1);
            chk("busy_with_strobe", int'(busy), 1);
        end else if (m_in && m_vec != 4'b0) begin
            m_w = m_w + 1;
            if (sw != m_sw) m_sw_ok = 1'b0;
            if (m_vec != m_cur) begin
                chk("strobe_change", int'(m_vec), int'(m_cur));
            end
        end else if (m_in) begin
            exp_t e;
            m_in   = 1'b0;
            pulses = pulses + 1;
            tests  = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_strobe: kind %0d at edge %0d, expected none",
                         m_kind, m_rise);
            end else begin
                e = exp_q.pop_front();
                if (m_kind != e.kind || m_rise != e.rise ||
                    m_w != e.width || int'(m_sw) != e.swv || !m_sw_ok) begin
                    fails = fails + 1;
                    $display("FAIL pulse: got kind=%0d rise=%0d w=%0d sw=%h stable=%0d, expected kind=%0d rise=%0d w=%0d sw=%h stable=1",
                             m_kind, m_rise, m_w, m_sw, m_sw_ok,
                             e.kind, e.rise, e.width, e.swv[11:0]);
                end
            end
        end
        if (!m_busy_q && busy) begin
            busy_rises = busy_rises + 1;
            chk("busy_rise_with_strobe", int'(m_vec != 4'b0), 1);
        end
        if (m_busy_q && !busy) begin
            if (idle_q.size() == 0) begin
                chk("unexpected_idle", cyc, -1);
            end else begin
                chk("idle_edge", cyc, idle_q.pop_front());
            end
        end
        m_busy_q = busy;
    end

`ifdef Q2_PANEL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    int k;
    int r;
    int br;

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        btn_incp  = 1'b0;
        btn_dep   = 1'b0;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        run       = 1'b0;
        sw_raw    = 12'h3C3;
        step(3);
        chk("rst_strobes", int'({stop_sw, start_sw, dep_sw, incp_sw}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sw", int'(sw), 0);
        rst = 1'b1;
        step(4);
        chk("sw_track_idle", int'(sw), 'h3C3);

        // Glitch shorter than DEBOUNCE.
        br = busy_rises;
        btn_dep = 1'b1;
        step(3);
        btn_dep = 1'b0;
        step(15);
        chk("glitch_no_busy", busy_rises - br, 0);

        // Clean deposit, switches change after dep_sw rises.
        sw_raw = 12'hA5C;
        step(4);
        k = cyc;
        btn_dep = 1'b1;
        push(K_DEP, k + 7, 2, 'hA5C);
        if (AUTOINC) begin
            push(K_INC, k + 10, 2, 'hA5C);
            idle_q.push_back(k + 13);
        end else begin
            idle_q.push_back(k + 10);
        end
        step(8);
        sw_raw = 12'h000;
        step(12);
        btn_dep = 1'b0;
        step(15);
        chk("sw_after_dep", int'(sw), 0);

        // Run lockout of dep/incp; stop still accepted.
        run = 1'b1;
        br  = busy_rises;
        btn_dep = 1'b1;
        step(10);
        btn_dep = 1'b0;
        step(10);
        btn_incp = 1'b1;
        step(10);
        btn_incp = 1'b0;
        step(10);
        chk("run_lockout", busy_rises - br, 0);
        k = cyc;
        btn_stop = 1'b1;
        push(K_STOP, k + 7, 2, 0);
        idle_q.push_back(k + 10);
        step(10);
        btn_stop = 1'b0;
        step(10);
        run = 1'b0;

        // Simultaneous start/stop: stop wins.
        k = cyc;
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        push(K_STOP, k + 7, 2, 0);
        idle_q.push_back(k + 10);
        step(12);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        step(15);

        // Start re-press landing in GAP is dropped.
        k = cyc;
        btn_stop = 1'b1;
        push(K_STOP, k + 7, 2, 0);
        idle_q.push_back(k + 10);
        step(3);
        btn_start = 1'b1;
        step(12);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        step(15);

        // Reset abort while dep_sw is high.
        sw_raw = 12'h5A3;
        step(4);
        k = cyc;
        btn_dep = 1'b1;
        push(K_DEP, k + 7, 1, 'h5A3);
        idle_q.push_back(k + 8);
        step(7);
        chk("abort_pre_dep", int'(dep_sw), 1);
        rst = 1'b0;
        #1;
        chk("abort_dep", int'(dep_sw), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sw", int'(sw), 0);
        step(2);
        r = cyc;
        rst = 1'b1;
        push(K_DEP, r + 7, 2, 'h5A3);
        if (AUTOINC) begin
            push(K_INC, r + 10, 2, 'h5A3);
            idle_q.push_back(r + 13);
        end else begin
            idle_q.push_back(r + 10);
        end
        step(20);
        btn_dep = 1'b0;
        step(15);

        // Long hold gives one strobe only.
        k = cyc;
        btn_incp = 1'b1;
        push(K_INC, k + 7, 2, 'h5A3);
        idle_q.push_back(k + 10);
        step(100);
        btn_incp = 1'b0;
        step(15);

        chk("pending_strobes", exp_q.size(), 0);
        chk("pending_idles", idle_q.size(), 0);
        chk("final_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
